rx_frame_buffer: RTL and testbench

- Store-and-forward frame buffer directly downstream of the MII/RMII receive MAC.
- The MAC's output stream has no backpressure. On that stream, tuser=1 on the tlast beat marks an FCS error or PHY error.
- This block buffers each received frame in full and releases only good frames to a backpressured AXI-Stream consumer (ARP/IP parser). Bad, truncated and overflowed frames are discarded without reaching the consumer.

---
 rtl/rx_frame_buffer.sv | 113 +++++++++++
 tb/tb_rx_frame_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive frame buffer: buffers whole MAC frames, releases only good
// frames to a backpressured AXI-Stream consumer, and counts discarded frames.
module rx_frame_buffer #(
  parameter int unsigned DEPTH_BITS   = 11,
  parameter int unsigned COUNTER_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              saxis_tdata,
  input  logic                    saxis_tvalid,
  input  logic                    saxis_tuser,
  input  logic                    saxis_tlast,
  output logic [7:0]              maxis_tdata,
  output logic                    maxis_tvalid,
  input  logic                    maxis_tready,
  output logic                    maxis_tlast,
  output logic [COUNTER_BITS-1:0] dropped_frames,
  output logic [COUNTER_BITS-1:0] overflow_frames
);

  localparam int unsigned PW    = DEPTH_BITS + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [8:0]    mem [DEPTH];
  logic [8:0]    mem_q;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, used;
  logic          ovf, full, wr_en, good, ovf_eff;
  logic          pending, pop, rd_en;
  logic [1:0]    cnt;
  logic [2:0]    fill;
  logic [8:0]    head, skid;

  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == PW'(DEPTH));
  assign wr_en   = saxis_tvalid && !full && !ovf && !reset;
  assign good    = wr_en && !saxis_tuser;
  assign ovf_eff = ovf || full;

  assign pop   = maxis_tvalid && maxis_tready;
  // Occupancy once the in-flight read lands; a new read needs a slot left after that.
  assign fill  = 3'(cnt) + 3'(pending) - 3'(pop);
  assign rd_en = (rd_ptr != commit_ptr) && (fill <= 3'd1);

  assign maxis_tvalid = (cnt != 2'd0);
  assign maxis_tdata  = head[7:0];
  assign maxis_tlast  = head[8];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[DEPTH_BITS-1:0]] <= {saxis_tlast, saxis_tdata};
    if (rd_en) mem_q <= mem[rd_ptr[DEPTH_BITS-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      rd_ptr          <= '0;
      ovf             <= 1'b0;
      dropped_frames  <= '0;
      overflow_frames <= '0;
      pending         <= 1'b0;
      cnt             <= 2'd0;
      head            <= '0;
      skid            <= '0;
    end else begin
      if (saxis_tvalid) begin
        if (saxis_tlast) begin
          ovf <= 1'b0;
          if (good) begin
            wr_ptr     <= wr_ptr + PW'(1);
            commit_ptr <= wr_ptr + PW'(1);
          end else begin
            wr_ptr <= commit_ptr;
            if (!ovf_eff && saxis_tuser) begin
              if (dropped_frames != '1) dropped_frames <= dropped_frames + COUNTER_BITS'(1);
            end else begin
              if (overflow_frames != '1) overflow_frames <= overflow_frames + COUNTER_BITS'(1);
            end
          end
        end else begin
          if (wr_en) wr_ptr <= wr_ptr + PW'(1);
          if (full) ovf <= 1'b1;
        end
      end

      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      pending <= rd_en;

      // head drives the outputs directly; skid holds the second byte while stalled.
      case ({pending, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= mem_q;
          else             skid <= mem_q;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= skid;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            head <= skid;
            skid <= mem_q;
          end else begin
            head <= mem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed self-checking bench for rx_frame_buffer (instantiated with a 256-byte buffer).
module tb_rx_frame_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  saxis_tdata = '0;
  logic        saxis_tvalid = 1'b0;
  logic        saxis_tuser = 1'b0;
  logic        saxis_tlast = 1'b0;
  logic [7:0]  maxis_tdata;
  logic        maxis_tvalid;
  logic        maxis_tready = 1'b0;
  logic        maxis_tlast;
  logic [15:0] dropped_frames, overflow_frames;

  rx_frame_buffer #(.DEPTH_BITS(8), .COUNTER_BITS(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .saxis_tdata     (saxis_tdata),
    .saxis_tvalid    (saxis_tvalid),
    .saxis_tuser     (saxis_tuser),
    .saxis_tlast     (saxis_tlast),
    .maxis_tdata     (maxis_tdata),
    .maxis_tvalid    (maxis_tvalid),
    .maxis_tready    (maxis_tready),
    .maxis_tlast     (maxis_tlast),
    .dropped_frames  (dropped_frames),
    .overflow_frames (overflow_frames)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  int         first_cyc = -1;
  int         last_cyc = 0;
  int         last_tcycle = 0;
  int         hold_errs = 0;
  logic       stall_prev = 1'b0;
  logic [8:0] stall_val = '0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         done;

  // Output monitor, sampled mid-cycle; also flags any change of a stalled beat.
  always @(negedge clock) begin
    if (stall_prev && !(maxis_tvalid && {maxis_tlast, maxis_tdata} == stall_val)) hold_errs++;
    stall_prev = maxis_tvalid && !maxis_tready && !reset;
    stall_val  = {maxis_tlast, maxis_tdata};
    if (maxis_tvalid && maxis_tready && !reset) begin
      got.push_back({maxis_tlast, maxis_tdata});
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int want);
    n_cmp++;
    if (obs != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic clear_q();
    got.delete();
    exp_q.delete();
    first_cyc = -1;
  endtask

  task automatic send_frame(input int n, input int base, input bit bad, input bit with_last,
                            input bit expect_out);
    for (int i = 0; i < n; i++) begin
      saxis_tvalid = 1'b1;
      saxis_tdata  = 8'(base + i);
      saxis_tlast  = with_last && (i == n - 1);
      saxis_tuser  = bad && saxis_tlast;
      if (saxis_tlast) last_tcycle = cyc;
      if (expect_out) exp_q.push_back({saxis_tlast, saxis_tdata});
      @(posedge clock); #1;
    end
    saxis_tvalid = 1'b0;
    saxis_tlast  = 1'b0;
    saxis_tuser  = 1'b0;
  endtask

  task automatic drain(input string tag, input bit toggle);
    int n = 0;
    int errs = 0;
    while (got.size() < exp_q.size() && n < 20000) begin
      @(posedge clock); #1;
      if (toggle) maxis_tready = ~maxis_tready;
      n++;
    end
    repeat (8) @(posedge clock);
    #1;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] != exp_q[i]) errs++;
    check_eq({tag, "_count"}, got.size(), exp_q.size());
    check_eq({tag, "_data_errs"}, errs, 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_tvalid", maxis_tvalid, 0);
    check_eq("rst_tdata", maxis_tdata, 0);
    check_eq("rst_tlast", maxis_tlast, 0);
    check_eq("rst_dropped", dropped_frames, 0);
    check_eq("rst_overflow", overflow_frames, 0);
    reset = 1'b0;

    // Single good frame: first byte valid three cycles after the tlast cycle.
    clear_q();
    maxis_tready = 1'b1;
    send_frame(64, 0, 1'b0, 1'b1, 1'b1);
    drain("t1", 1'b0);
    check_eq("t1_latency", first_cyc, last_tcycle + 3);
    check_eq("t1_dropped", dropped_frames, 0);
    check_eq("t1_overflow", overflow_frames, 0);

    // Bad frame discarded, following good frame passes.
    clear_q();
    send_frame(60, 8'h80, 1'b1, 1'b1, 1'b0);
    send_frame(60, 8'h40, 1'b0, 1'b1, 1'b1);
    drain("t2", 1'b0);
    check_eq("t2_dropped", dropped_frames, 1);
    check_eq("t2_overflow", overflow_frames, 0);

    // Three back-to-back frames with tready toggling every cycle.
    clear_q();
    done = 1'b0;
    fork
      begin
        send_frame(100, 0, 1'b0, 1'b1, 1'b1);
        send_frame(100, 100, 1'b0, 1'b1, 1'b1);
        send_frame(100, 200, 1'b0, 1'b1, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock); #1;
          maxis_tready = ~maxis_tready;
        end
      end
    join
    drain("t3", 1'b1);
    begin
      int nl = 0;
      foreach (got[i]) nl += int'(got[i][8]);
      check_eq("t3_tlast_count", nl, 3);
    end
    maxis_tready = 1'b1;

    // Overflow: 200-byte frame held, 100-byte frame cannot fit.
    clear_q();
    maxis_tready = 1'b0;
    send_frame(200, 1, 1'b0, 1'b1, 1'b1);
    send_frame(100, 8'h55, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check_eq("t4_overflow", overflow_frames, 1);
    check_eq("t4_dropped", dropped_frames, 1);
    check_eq("t4_no_output_yet", got.size(), 0);
    maxis_tready = 1'b1;
    send_frame(50, 8'hA0, 1'b0, 1'b1, 1'b1);
    drain("t4", 1'b0);
    check_eq("t4_overflow_after", overflow_frames, 1);

    // Wrap-around with sustained one byte per cycle.
    clear_q();
    for (int k = 0; k < 50; k++) send_frame(90, k * 5, 1'b0, 1'b1, 1'b1);
    drain("t5", 1'b0);
    check_eq("t5_span", last_cyc - first_cyc, 4499);

    // Reset mid-frame with a committed unread frame pending.
    clear_q();
    maxis_tready = 1'b0;
    send_frame(20, 8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(30, 8'h70, 1'b0, 1'b0, 1'b0);
    check_eq("t6_pre_tvalid", maxis_tvalid, 1);
    reset        = 1'b1;
    saxis_tvalid = 1'b1;
    saxis_tdata  = 8'h99;
    saxis_tlast  = 1'b1;
    @(posedge clock); #1;
    check_eq("t6_tvalid", maxis_tvalid, 0);
    check_eq("t6_tdata", maxis_tdata, 0);
    check_eq("t6_tlast", maxis_tlast, 0);
    check_eq("t6_dropped", dropped_frames, 0);
    check_eq("t6_overflow", overflow_frames, 0);
    reset        = 1'b0;
    saxis_tvalid = 1'b0;
    saxis_tlast  = 1'b0;
    clear_q();
    maxis_tready = 1'b1;
    send_frame(40, 8'h30, 1'b0, 1'b1, 1'b1);
    drain("t6", 1'b0);
    check_eq("t6_counters", int'(dropped_frames) + int'(overflow_frames), 0);

    check_eq("hold_errs", hold_errs, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
